execute_pipe: RTL and testbench
===============================

# execute_pipe

Parametrised, pipelined Y86-64 execute stage: registered successor to the combinational `execute` block. It takes one decoded instruction per handshake from the decode/E register and computes `valE` and `cnd`. It holds the condition-code register internally and presents a single-entry output register to the memory stage. Datapath width is generic, and an optional iterative multiplier adds a multi-cycle `mulq`.

## Interface
- XLEN, 64, datapath width; multiple of 8, ≥ 16
- STACK_STEP, XLEN/8, push/pop/call/ret stack-pointer adjustment
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- icode  in  4  instruction code
- ifun  in  4  function code
- valA, valB, valC  in  XLEN each  operands; valC is the immediate/offset
- set_cc_en  in  1  0 suppresses the CC update (downstream exception)
- out_valid  out  1  output register holds a result
- out_ready  in  1  memory stage consumes the result
- out_icode, out_ifun  out  4 each  passed-through codes
- out_valA  out  XLEN  passed-through valA
- out_valE  out  XLEN  ALU result
- out_cnd  out  1  condition result for cmovXX/jXX
- out_err  out  1  invalid OPq function
- cndflags  out  3  CC register: [0]=ZF, [1]=SF, [2]=OF
- busy  out  1  multiplier in progress

## Operation
- The stage accepts an instruction when `in_valid && in_ready`.
- `in_ready = !busy && (!out_valid || out_ready)`.
- valE rules:
  - OPq (6): valB op valA; ifun 0 add, 1 sub (valB−valA), 2 and, 3 xor.
  - rrmovq/cmovXX (2): valA.
  - irmovq (3): valC.
  - rmmovq/mrmovq (4/5): valB+valC.
  - call/pushq (8/A): valB−STACK_STEP.
  - ret/popq (9/B): valB+STACK_STEP.
  - All other icodes: 0.
- All arithmetic is modulo 2^XLEN.
- Flag rules on an OPq result r:
  - ZF = (r==0); SF = r[XLEN−1].
  - OF for add: operands share a sign and r's sign differs.
  - OF for sub: signs of valB and valA differ and r's sign differs from valB.
  - OF = 0 for and/xor.
- The CC register is written only for an accepted valid OPq with set_cc_en=1. All other instructions leave the CC unchanged.
- out_cnd is evaluated from the CC register value at acceptance, for icode 2 and 7 only; it is 0 otherwise.
  - ifun 0 always
  - ifun 1 le: (SF^OF)|ZF
  - ifun 2 l: SF^OF
  - ifun 3 e: ZF
  - ifun 4 ne: !ZF
  - ifun 5 ge: !(SF^OF)
  - ifun 6 g: !(SF^OF)&!ZF
  - ifun 7–15: 0
- OPq with ifun ≥ 4 (except mulq when enabled): out_err=1, valE=0, CC unchanged, out_valid asserted normally.
- FSM states: IDLE, MUL, DONE.
  - IDLE → MUL only on an accepted mulq.
  - MUL → DONE after XLEN iterations.
  - DONE → IDLE when the result loads into the output register, provided that register is free or being consumed.
- The output register holds its contents while `out_valid && !out_ready`.

## Timing
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_err=0, out_cnd=0, busy=0.
  - All data outputs = 0.
  - cndflags=3'b001 (ZF=1).
  - FSM = IDLE.
- Single-cycle ops: accepted at edge N, out_valid=1 and results valid after edge N; the CC update lands at the same edge.
- The next instruction accepted at edge N+1 sees the updated CC.
- Full throughput of one instruction per cycle when out_ready=1 continuously.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0, and outputs and CC hold stable.
- Simultaneous consume and accept: the register reloads in the same cycle with no bubble.
- mulq (macro enabled): busy=1 from the edge after acceptance for XLEN cycles. The result and CC are written when DONE loads the output register. Minimum latency is XLEN+1 cycles.
- Reset mid-multiply aborts the operation: no output, CC left at its reset value.

## Configuration
- EXECUTE_MUL_EN defined: OPq ifun 4 = mulq.
  - Unsigned shift-add, one multiplier bit per cycle; valE = low XLEN bits of valB×valA.
  - ZF/SF from the result, OF=0; CC gated by set_cc_en as sampled at acceptance.
- Undefined: the MUL/DONE states and the multiplier datapath are removed, busy is tied to 0, and ifun 4 follows the out_err rule.

## Test plan
- XLEN=64, out_ready=1, add 15+10 then sub 15−10 back-to-back → valE 25 then 5, flags 000 after each, one result per cycle.
- Add valB=0x7FFF_FFFF_FFFF_FFFF, valA=2 → valE=0x8000_0000_0000_0001, cndflags=3'b110.
- Sub valB=10, valA=10 (ZF=1), then cmovle, cmovne, jg → out_cnd 1, 0, 0; CC unchanged by the cmov/jXX.
- Hold out_ready=0 for 3 cycles after an accepted OPq → in_ready=0, outputs stable; release → next instruction accepted the same cycle.
- OPq set_cc_en=0 giving result 0 → cndflags keeps its prior value; OPq ifun 5 → out_err=1, valE=0.
- EXECUTE_MUL_EN, XLEN=16: mulq 300×7 → busy high for 16 cycles, valE=2100, ZF=0; assert rst_n=0 mid-multiply → out_valid=0, cndflags=001.

Source files
------------

// File: rtl/execute_pipe.sv
// Pipelined Y86-64 execute stage: ALU, condition codes and a single-entry output register.
// Define EXECUTE_MUL_EN to add an iterative shift-add mulq (OPq ifun 4).
module execute_pipe #(
  parameter int XLEN       = 64,
  parameter int STACK_STEP = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      icode,
  input  logic [3:0]      ifun,
  input  logic [XLEN-1:0] valA,
  input  logic [XLEN-1:0] valB,
  input  logic [XLEN-1:0] valC,
  input  logic            set_cc_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_icode,
  output logic [3:0]      out_ifun,
  output logic [XLEN-1:0] out_valA,
  output logic [XLEN-1:0] out_valE,
  output logic            out_cnd,
  output logic            out_err,
  output logic [2:0]      cndflags,
  output logic            busy,
  output logic [1:0]      fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] STEP = XLEN'(STACK_STEP);

  // Handshake: a transfer happens on any edge where valid && ready are both high;
  // valid never depends on ready, and a held output stays stable until consumed.
  logic            accept;
  logic            is_opq;
  logic            is_mul;
  logic            alu_err;
  logic [XLEN-1:0] alu_res;
  logic            alu_of;
  logic            cnd;
  logic            done_load;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] mul_valA;
  logic            mul_setcc;
  logic [2:0]      cc;
  logic [1:0]      state;

  assign is_opq = (icode == 4'h6);
`ifdef EXECUTE_MUL_EN
  assign is_mul = is_opq && (ifun == 4'h4);
`else
  assign is_mul = 1'b0;
`endif

  assign in_ready  = !busy && (state != S_DONE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign cndflags  = cc;
  assign fsm_state = state;

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    alu_err = 1'b0;
    case (icode)
      4'h2:        alu_res = valA;
      4'h3:        alu_res = valC;
      4'h4, 4'h5:  alu_res = valB + valC;
      4'h8, 4'hA:  alu_res = valB - STEP;
      4'h9, 4'hB:  alu_res = valB + STEP;
      4'h6: begin
        case (ifun)
          4'h0: begin
            alu_res = valB + valA;
            alu_of  = (valB[XLEN-1] == valA[XLEN-1]) && (alu_res[XLEN-1] != valB[XLEN-1]);
          end
          4'h1: begin
            alu_res = valB - valA;
            alu_of  = (valB[XLEN-1] != valA[XLEN-1]) && (alu_res[XLEN-1] != valB[XLEN-1]);
          end
          4'h2:    alu_res = valB & valA;
          4'h3:    alu_res = valB ^ valA;
          default: alu_err = !is_mul;
        endcase
      end
      default:     alu_res = '0;
    endcase
  end

  // Condition uses the CC value held at acceptance, before any same-edge update.
  always_comb begin
    cnd = 1'b0;
    if (icode == 4'h2 || icode == 4'h7) begin
      case (ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (cc[1] ^ cc[2]) | cc[0];
        4'h2:    cnd = cc[1] ^ cc[2];
        4'h3:    cnd = cc[0];
        4'h4:    cnd = !cc[0];
        4'h5:    cnd = !(cc[1] ^ cc[2]);
        4'h6:    cnd = !(cc[1] ^ cc[2]) && !cc[0];
        default: cnd = 1'b0;
      endcase
    end
  end

`ifdef EXECUTE_MUL_EN
  localparam int CNT_W = $clog2(XLEN);
  logic [CNT_W-1:0] mul_cnt;
  logic [XLEN-1:0]  mul_mcand;
  logic [XLEN-1:0]  mul_mplier;

  assign busy      = (state == S_MUL);
  assign done_load = (state == S_DONE) && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mul_cnt    <= '0;
      mul_res    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_valA   <= '0;
      mul_setcc  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept && is_mul) begin
          state      <= S_MUL;
          mul_cnt    <= '0;
          mul_res    <= '0;
          mul_mcand  <= valB;
          mul_mplier <= valA;
          mul_valA   <= valA;
          mul_setcc  <= set_cc_en;
        end
        S_MUL: begin
          if (mul_mplier[0]) mul_res <= mul_res + mul_mcand;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + 1'b1;
          if (mul_cnt == CNT_W'(XLEN - 1)) state <= S_DONE;
        end
        S_DONE: if (done_load) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign state     = S_IDLE;
  assign busy      = 1'b0;
  assign done_load = 1'b0;
  assign mul_res   = '0;
  assign mul_valA  = '0;
  assign mul_setcc = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= 3'b001;
    end else if (done_load) begin
      if (mul_setcc) cc <= {1'b0, mul_res[XLEN-1], (mul_res == '0)};
    end else if (accept && is_opq && !is_mul && !alu_err && set_cc_en) begin
      cc <= {alu_of, alu_res[XLEN-1], (alu_res == '0)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_icode <= '0;
      out_ifun  <= '0;
      out_valA  <= '0;
      out_valE  <= '0;
      out_cnd   <= 1'b0;
      out_err   <= 1'b0;
    end else if (done_load) begin
      out_valid <= 1'b1;
      out_icode <= 4'h6;
      out_ifun  <= 4'h4;
      out_valA  <= mul_valA;
      out_valE  <= mul_res;
      out_cnd   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      out_icode <= icode;
      out_ifun  <= ifun;
      out_valA  <= valA;
      out_valE  <= alu_res;
      out_cnd   <= cnd;
      out_err   <= alu_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe at XLEN=64; mulq steps run when EXECUTE_MUL_EN is defined.
module tb_execute_pipe;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      icode;
  logic [3:0]      ifun;
  logic [XLEN-1:0] valA;
  logic [XLEN-1:0] valB;
  logic [XLEN-1:0] valC;
  logic            set_cc_en;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_icode;
  logic [3:0]      out_ifun;
  logic [XLEN-1:0] out_valA;
  logic [XLEN-1:0] out_valE;
  logic            out_cnd;
  logic            out_err;
  logic [2:0]      cndflags;
  logic            busy;
  logic [1:0]      fsm_state;

  int checks = 0;
  int errors = 0;

  execute_pipe #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .set_cc_en(set_cc_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_ifun(out_ifun), .out_valA(out_valA),
    .out_valE(out_valE), .out_cnd(out_cnd), .out_err(out_err),
    .cndflags(cndflags), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic cc_en);
    in_valid  = 1'b1;
    icode     = ic;
    ifun      = fn;
    valA      = a;
    valB      = b;
    valC      = c;
    set_cc_en = cc_en;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic cc_en);
    set_in(ic, fn, a, b, c, cc_en);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0; set_cc_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cndflags", cndflags, 3'b001);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valE", out_valE, '0);
    chk("rst_state", fsm_state, 2'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1'b1);

    issue(4'h6, 4'h0, 64'd10, 64'd15, 64'd0, 1'b1);
    chk("add_valid", out_valid, 1'b1);
    chk("add_valE", out_valE, 64'd25);
    chk("add_flags", cndflags, 3'b000);
    issue(4'h6, 4'h1, 64'd10, 64'd15, 64'd0, 1'b1);
    chk("sub_valid", out_valid, 1'b1);
    chk("sub_valE", out_valE, 64'd5);
    chk("sub_flags", cndflags, 3'b000);

    issue(4'h6, 4'h0, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    chk("ovf_valE", out_valE, 64'h8000_0000_0000_0001);
    chk("ovf_flags", cndflags, 3'b110);

    issue(4'h6, 4'h1, 64'd10, 64'd10, 64'd0, 1'b1);
    chk("zero_valE", out_valE, 64'd0);
    chk("zero_flags", cndflags, 3'b001);
    issue(4'h2, 4'h1, 64'hAB, 64'd0, 64'd0, 1'b1);
    chk("cmovle_cnd", out_cnd, 1'b1);
    chk("cmovle_valE", out_valE, 64'hAB);
    chk("cmovle_flags", cndflags, 3'b001);
    issue(4'h2, 4'h4, 64'hCD, 64'd0, 64'd0, 1'b1);
    chk("cmovne_cnd", out_cnd, 1'b0);
    issue(4'h7, 4'h6, 64'd0, 64'd0, 64'h400, 1'b1);
    chk("jg_cnd", out_cnd, 1'b0);
    chk("jg_valE", out_valE, 64'd0);
    chk("jg_flags", cndflags, 3'b001);

    issue(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 1'b1);
    chk("bp_first_valE", out_valE, 64'd3);
    out_ready = 1'b0;
    set_in(4'h6, 4'h3, 64'hFF, 64'hF0, 64'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #0;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valE_hold", out_valE, 64'd3);
      chk("bp_valid_hold", out_valid, 1'b1);
      chk("bp_flags_hold", cndflags, 3'b000);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_xor_valE", out_valE, 64'h0F);
    chk("bp_xor_icode", out_ifun, 4'h3);

    issue(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 1'b1);
    chk("irmov_valE", out_valE, 64'h1234);
    issue(4'h4, 4'h0, 64'h55, 64'h100, 64'h8, 1'b1);
    chk("rmmov_valE", out_valE, 64'h108);
    chk("rmmov_valA", out_valA, 64'h55);
    issue(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1);
    chk("push_valE", out_valE, 64'hF8);
    issue(4'h9, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1);
    chk("ret_valE", out_valE, 64'h108);
    issue(4'h1, 4'h0, 64'd7, 64'd9, 64'd3, 1'b1);
    chk("nop_valE", out_valE, 64'd0);

    issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b0);
    chk("nocc_valE", out_valE, 64'd0);
    chk("nocc_flags", cndflags, 3'b000);
    issue(4'h6, 4'h5, 64'd3, 64'd4, 64'd0, 1'b1);
    chk("bad_fn_err", out_err, 1'b1);
    chk("bad_fn_valE", out_valE, 64'd0);
    chk("bad_fn_valid", out_valid, 1'b1);
    chk("bad_fn_flags", cndflags, 3'b000);

`ifdef EXECUTE_MUL_EN
    issue(4'h6, 4'h4, 64'd7, 64'd300, 64'd0, 1'b1);
    busy_cycles = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      busy_cycles++;
      if (i == 3) chk("mul_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("mul_busy_cycles", busy_cycles, XLEN);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mul_valid", out_valid, 1'b1);
    chk("mul_valE", out_valE, 64'd2100);
    chk("mul_err", out_err, 1'b0);
    chk("mul_flags", cndflags, 3'b000);
    issue(4'h6, 4'h4, 64'd3, 64'd9, 64'd0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mulrst_valid", out_valid, 1'b0);
    chk("mulrst_flags", cndflags, 3'b001);
    chk("mulrst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (XLEN + 4) @(posedge clk);
    #1;
    chk("mulrst_no_out", out_valid, 1'b0);
`else
    busy_cycles = 0;
    issue(4'h6, 4'h4, 64'd7, 64'd300, 64'd0, 1'b1);
    chk("fn4_err", out_err, 1'b1);
    chk("fn4_valE", out_valE, 64'd0);
    chk("fn4_busy", busy, 1'b0);
    chk("fn4_flags", cndflags, 3'b000);
`endif

    @(posedge clk);
    #1;
    chk("drain_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
